regfile_arbiter: RTL
====================

# regfile_arbiter

Two-requester write arbiter and controller for a bank of 4-bit registers built from the team's `dfrl` cells (D flip-flop with synchronous reset and load enable). It accepts write requests from two independent masters (A and B) and arbitrates between them round-robin. It drives exactly one register's `load` for exactly one cycle per granted write and returns a one-cycle acknowledge to the winner. A combinational read port exposes any register's current contents.

## Interface
- `WIDTH`, default 4: data width of each register.
- `NREG`, default 4: number of registers. Address width is 2 bits; `NREG` must be 4 for this revision.
- `clk`  in  1  rising-edge clock for all state.
- `reset`  in  1  synchronous, active-high reset.
- `a_req`  in  1  master A write request, level-sensitive.
- `a_addr`  in  2  master A target register.
- `a_data`  in  WIDTH  master A write data.
- `a_ack`  out  1  one-cycle pulse: A's write has completed.
- `b_req`, `b_addr`, `b_data`, `b_ack`: same as the A signals, for master B.
- `rd_addr`  in  2  read select.
- `rd_data`  out  WIDTH  contents of register `rd_addr`, combinational.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- Storage: `NREG` × `WIDTH` `dfrl` bits.
  - Each register's `reset` is tied to the block `reset`.
  - Each register's `in` is the latched write data.
  - Each register's `load` is asserted only when the state is WRITE and the latched address matches that register.
- The FSM has three states.
  - IDLE: samples `a_req`/`b_req`.
    - No request: stay in IDLE.
    - One request: grant it.
    - Both requests: grant the master that was not granted last (`last` flag).
    - On grant: latch the winner's addr and data into holding registers, record the winner, update `last`, and go to WRITE.
  - WRITE: assert `load` for the latched address. The register updates at the end of this cycle. Go to ACK.
  - ACK: assert the winner's ack (`a_ack` or `b_ack`) for this cycle only. Go to IDLE.
- Requests are not sampled in WRITE or ACK. A request arriving during those states waits until IDLE.
- The requester must drive addr/data stable only in the cycle its request is sampled in IDLE.
- The requester must deassert req in the cycle after it sees ack high. A req still high in IDLE is treated as a new request.
- Exactly one register is loaded per grant. No other register changes.
- `rd_data` is a pure mux of the register outputs and is never gated by state.

## Timing
- Reset values:
  - All registers: 0.
  - State: IDLE.
  - `a_ack`, `b_ack`, `busy`: 0.
  - Holding registers: 0.
  - `last` = B, so A wins the first contention.
- Write latency: request sampled at cycle n (IDLE) → WRITE in n+1 → new value visible on `rd_data` and ack high in n+2 → IDLE in n+3.
- Throughput: at most one write per 3 cycles.
- Read during write to the same address: old value in the WRITE cycle, new value from the ACK cycle onward.
- Continuous contention: grants alternate A, B, A, B…, one per 3 cycles.
- Reset asserted in any state: at the next edge the state returns to IDLE and all registers clear. An in-flight write is discarded and no ack is issued.
  - Reset dominates load, as in `dfr`.
- `a_ack` and `b_ack` are never high together. An ack only ever appears in the ACK state.

## Test plan
- After reset: `rd_data` = 0 for all 4 addresses; `busy` = 0; no acks.
- A alone writes addr 2, data 0xA at cycle 0:
  - cycle 2: `a_ack` = 1 and `rd_data`@2 = 0xA.
  - `busy` is high in cycles 1–2.
  - Addresses 0, 1, 3 remain 0.
- A (addr 1, 0x5) and B (addr 3, 0xC) request together from reset:
  - A is acked at cycle 2.
  - B, holding req, is granted at cycle 3 and acked at cycle 5.
  - Final contents: reg1 = 0x5, reg3 = 0xC.
- Both masters hold req continuously for 12 cycles:
  - ack sequence is A, B, A, B at cycles 2, 5, 8, 11.
  - never both acks high in the same cycle.
- Read during write: `rd_addr` = 0 while A writes 0xF to addr 0 over an old value of 0x3:
  - `rd_data` = 0x3 in the WRITE cycle and 0xF in the ACK cycle.
- Reset mid-operation: assert reset in the WRITE cycle of a write of 0x9 to addr 1:
  - next cycle: state IDLE, reg1 = 0, no `a_ack`.
  - A fresh request afterwards completes normally in 3 cycles.

Source files
------------

// File: rtl/regfile_arbiter_if.sv
// Write/read bundle between two writing masters and the register-file arbiter.
// Latency: n/a (signal grouping only).
// Backpressure: master holds req level until its one-cycle ack pulse.
interface regfile_arbiter_if #(
    parameter int WIDTH = 4
);
    logic             a_req;
    logic [1:0]       a_addr;
    logic [WIDTH-1:0] a_data;
    logic             a_ack;
    logic             b_req;
    logic [1:0]       b_addr;
    logic [WIDTH-1:0] b_data;
    logic             b_ack;
    logic [1:0]       rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             busy;

    modport master (
        output a_req, a_addr, a_data, b_req, b_addr, b_data, rd_addr,
        input  a_ack, b_ack, rd_data, busy
    );

    modport slave (
        input  a_req, a_addr, a_data, b_req, b_addr, b_data, rd_addr,
        output a_ack, b_ack, rd_data, busy
    );
endinterface

// File: rtl/regfile_arbiter.sv
// Storage cell: register with synchronous reset and load enable.
// Latency: 1 cycle from load to output.
// Backpressure: none; reset dominates load.
module dfrl #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] in,
    output logic [W-1:0] out
);
    // Clear on reset, otherwise capture on load.
    always_ff @(posedge clk) begin
        if (reset) begin
            out <= '0;
        end else if (load) begin
            out <= in;
        end
    end
endmodule

// Two-master round-robin write arbiter in front of a bank of dfrl registers.
// Latency: request sampled in IDLE -> load next cycle -> ack + new data the cycle after.
// Backpressure: requests are only sampled in IDLE; a master holds req until it sees ack.
module regfile_arbiter #(
    parameter int WIDTH = 4,
    parameter int NREG  = 4
) (
    input  logic           clk,
    input  logic           reset,
    regfile_arbiter_if.slave bus
);
    localparam int AW = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_ACK   = 2'd2
    } state_t;

    state_t            state;
    logic              last_b;     // 1: B was the most recent winner
    logic              win_b;      // winner of the write in flight
    logic [AW-1:0]     hold_addr;
    logic [WIDTH-1:0]  hold_data;
    logic              a_ack_q;
    logic              b_ack_q;
    logic              busy_q;

    logic              grant_b;
    logic [AW-1:0]     grant_addr;
    logic [WIDTH-1:0]  grant_data;

    logic [NREG-1:0]   load;
    logic [WIDTH-1:0]  reg_q [NREG];

    // B wins when it is alone, or when both ask and A was served last.
    assign grant_b    = bus.b_req && (!bus.a_req || !last_b);
    assign grant_addr = grant_b ? bus.b_addr : bus.a_addr;
    assign grant_data = grant_b ? bus.b_data : bus.a_data;

    // Arbitration FSM; ack and busy are registered so they are glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            last_b    <= 1'b1;
            win_b     <= 1'b0;
            hold_addr <= '0;
            hold_data <= '0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.a_req || bus.b_req) begin
                        hold_addr <= grant_addr;
                        hold_data <= grant_data;
                        win_b     <= grant_b;
                        last_b    <= grant_b;
                        busy_q    <= 1'b1;
                        state     <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    a_ack_q <= !win_b;
                    b_ack_q <= win_b;
                    state   <= S_ACK;
                end
                S_ACK: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    // Register bank: only the latched address is loaded, and only in WRITE.
    for (genvar g = 0; g < NREG; g++) begin : g_reg
        assign load[g] = (state == S_WRITE) && (hold_addr == AW'(g));

        dfrl #(.W(WIDTH)) u_dfrl (
            .clk   (clk),
            .reset (reset),
            .load  (load[g]),
            .in    (hold_data),
            .out   (reg_q[g])
        );
    end

    // Read port is a plain mux, never gated by the FSM.
    assign bus.rd_data = reg_q[bus.rd_addr];
    assign bus.a_ack   = a_ack_q;
    assign bus.b_ack   = b_ack_q;
    assign bus.busy    = busy_q;
endmodule
